// File: rtl/hazard_controller.sv
// Hazard sequencer for the 5-stage core: load-use stalls, taken-branch flushes and
// multi-cycle mul/div occupancy of EX with watchdog, plus saturating event counters.
module hazard_controller #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_s2,
    input  logic [4:0]       rs2_s2,
    input  logic             uses_rs1_s2,
    input  logic             uses_rs2_s2,
    input  logic [4:0]       rd_s3,
    input  logic             MemRead_s3,
    input  logic             BrTaken_s3,
    input  logic             md_start_s3,
    input  logic             md_done,
    output logic             md_go,
    output logic             stall_s1,
    output logic             stall_s2,
    output logic             stall_s3,
    output logic             bubble_s3,
    output logic             flush_s2,
    output logic             bubble_s4,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WD_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              md_err_q, md_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              load_use;
    logic              md_timeout;
    logic              br_flush;

    assign load_use = MemRead_s3 && (rd_s3 != 5'd0) &&
                      ((uses_rs1_s2 && (rd_s3 == rs1_s2)) ||
                       (uses_rs2_s2 && (rd_s3 == rs2_s2)));

    // The md_go cycle is watchdog cycle 0, so the count lags the cycle index by one.
    assign md_timeout = (state_q == MD_WAIT) && !md_done &&
                        (wdog_q == WD_W'(MD_TIMEOUT - 2));

    assign br_flush = (state_q == RUN) && BrTaken_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wdog_q      <= '0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        case (state_q)
            RUN: begin
                if (!BrTaken_s3 && md_start_s3) begin
                    state_d = MD_WAIT;
                    wdog_d  = '0;
                end
            end
            MD_WAIT: begin
                if (md_done || md_timeout) begin
                    state_d = RUN;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Controls are forced low while reset is held so the pipeline sees no stale request.
    always_comb begin
        md_go     = 1'b0;
        stall_s1  = 1'b0;
        stall_s2  = 1'b0;
        stall_s3  = 1'b0;
        bubble_s3 = 1'b0;
        flush_s2  = 1'b0;
        bubble_s4 = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (BrTaken_s3) begin
                        flush_s2  = 1'b1;
                        bubble_s3 = 1'b1;
                    end else if (md_start_s3) begin
                        md_go     = 1'b1;
                        stall_s1  = 1'b1;
                        stall_s2  = 1'b1;
                        stall_s3  = 1'b1;
                        bubble_s4 = 1'b1;
                    end else if (load_use) begin
                        stall_s1  = 1'b1;
                        stall_s2  = 1'b1;
                        bubble_s3 = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!md_done && !md_timeout) begin
                        stall_s1  = 1'b1;
                        stall_s2  = 1'b1;
                        stall_s3  = 1'b1;
                        bubble_s4 = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        md_err_d    = md_err_q || md_timeout;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_s1 && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (br_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    assign md_err    = md_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with MD_TIMEOUT=8 and 4-bit counters.
module tb_hazard_controller;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b0110100;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_GO   = 7'b1111001;
    localparam logic [6:0] C_WAIT = 7'b0111001;

    logic             clk;
    logic             rst_n;
    logic [4:0]       rs1_s2, rs2_s2, rd_s3;
    logic             uses_rs1_s2, uses_rs2_s2;
    logic             MemRead_s3, BrTaken_s3, md_start_s3, md_done;
    logic             md_go, stall_s1, stall_s2, stall_s3;
    logic             bubble_s3, flush_s2, bubble_s4, md_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       ctrl;

    int checks   = 0;
    int failures = 0;

    hazard_controller #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_s2(rs1_s2), .rs2_s2(rs2_s2),
        .uses_rs1_s2(uses_rs1_s2), .uses_rs2_s2(uses_rs2_s2),
        .rd_s3(rd_s3), .MemRead_s3(MemRead_s3), .BrTaken_s3(BrTaken_s3),
        .md_start_s3(md_start_s3), .md_done(md_done),
        .md_go(md_go), .stall_s1(stall_s1), .stall_s2(stall_s2), .stall_s3(stall_s3),
        .bubble_s3(bubble_s3), .flush_s2(flush_s2), .bubble_s4(bubble_s4),
        .md_err(md_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctrl = {md_go, stall_s1, stall_s2, stall_s3, bubble_s3, flush_s2, bubble_s4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic br, input logic mds, input logic mdd, input logic mr,
                         input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2);
        BrTaken_s3  = br;
        md_start_s3 = mds;
        md_done     = mdd;
        MemRead_s3  = mr;
        rd_s3       = rd;
        rs1_s2      = r1;
        rs2_s2      = r2;
        uses_rs1_s2 = u1;
        uses_rs2_s2 = u2;
    endtask

    // New inputs land on the falling edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 1, 0, 1, 5, 5, 0, 1, 0);
        #3;
        chk("rst_ctrl", ctrl, C_IDLE);
        chk("rst_err", md_err, 0);
        chk("rst_scnt", stall_cnt, 0);
        chk("rst_fcnt", flush_cnt, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); rst_n = 1'b1;

        cyc(); drive(0, 0, 0, 1, 5, 5, 0, 1, 0); #1 chk("lu_rs1", ctrl, C_LU);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("lu_release", ctrl, C_IDLE);
        chk("lu_scnt", stall_cnt, 1);
        cyc(); drive(0, 0, 0, 1, 0, 0, 0, 1, 0); #1 chk("lu_x0", ctrl, C_IDLE);
        cyc(); drive(0, 0, 0, 1, 7, 3, 7, 1, 1); #1 chk("lu_rs2", ctrl, C_LU);
        cyc(); drive(0, 0, 0, 1, 7, 3, 7, 1, 0); #1 chk("lu_rs2_unused", ctrl, C_IDLE);
        chk("lu_scnt2", stall_cnt, 2);
        cyc(); drive(0, 0, 0, 0, 5, 5, 0, 1, 0); #1 chk("lu_not_load", ctrl, C_IDLE);

        cyc(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("br", ctrl, C_BR);
        chk("br_fcnt_before", flush_cnt, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("br_after", ctrl, C_IDLE);
        chk("br_fcnt", flush_cnt, 1);
        cyc(); drive(1, 0, 0, 1, 5, 5, 0, 1, 0); #1 chk("br_over_lu", ctrl, C_BR);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1
        chk("br_lu_scnt", stall_cnt, 2);
        chk("br_lu_fcnt", flush_cnt, 2);
        cyc(); drive(1, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("br_over_md", ctrl, C_BR);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("br_md_stays_run", ctrl, C_IDLE);
        chk("br_md_fcnt", flush_cnt, 3);

        cyc(); drive(0, 1, 0, 1, 5, 5, 0, 1, 0); #1 chk("md_go", ctrl, C_GO);
        for (int i = 1; i <= 3; i++) begin
            cyc(); drive(1, 1, 0, 1, 5, 5, 0, 1, 0); #1 chk($sformatf("md_wait%0d", i), ctrl, C_WAIT);
        end
        cyc(); drive(0, 1, 1, 0, 0, 0, 0, 0, 0); #1 chk("md_done", ctrl, C_IDLE);
        cyc(); drive(0, 0, 1, 0, 0, 0, 0, 0, 0); #1 chk("md_done_in_run", ctrl, C_IDLE);
        chk("md_scnt", stall_cnt, 6);
        cyc(); drive(0, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("b2b_go1", ctrl, C_GO);
        cyc(); drive(0, 1, 1, 0, 0, 0, 0, 0, 0); #1 chk("b2b_done1", ctrl, C_IDLE);
        cyc(); drive(0, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("b2b_go2", ctrl, C_GO);
        cyc(); drive(0, 1, 1, 0, 0, 0, 0, 0, 0); #1 chk("b2b_done2", ctrl, C_IDLE);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("b2b_scnt", stall_cnt, 8);
        chk("b2b_err", md_err, 0);

        cyc(); drive(0, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("wd_go", ctrl, C_GO);
        for (int i = 1; i <= 6; i++) begin
            cyc(); #1 chk($sformatf("wd_wait%0d", i), ctrl, C_WAIT);
        end
        cyc(); #1 chk("wd_fire_ctrl", ctrl, C_IDLE);
        chk("wd_err_pre", md_err, 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("wd_after_ctrl", ctrl, C_IDLE);
        chk("wd_err", md_err, 1);
        chk("wd_scnt_sat", stall_cnt, 15);
        cyc(); drive(0, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("wd_run_go", ctrl, C_GO);
        cyc(); drive(0, 0, 1, 0, 0, 0, 0, 0, 0); #1 chk("wd_run_done", ctrl, C_IDLE);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("wd_err_sticky", md_err, 1);
        chk("wd_scnt_hold", stall_cnt, 15);

        rst_n = 1'b0;
        #1 chk("rst2_err", md_err, 0);
        cyc(); rst_n = 1'b1;
        cyc(); drive(0, 1, 0, 0, 0, 0, 0, 0, 0); #1 chk("mid_go", ctrl, C_GO);
        cyc(); #1 chk("mid_wait1", ctrl, C_WAIT);
        cyc(); #1 chk("mid_wait2", ctrl, C_WAIT);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_ctrl", ctrl, C_IDLE);
        chk("mid_rst_scnt", stall_cnt, 0);
        chk("mid_rst_fcnt", flush_cnt, 0);
        chk("mid_rst_err", md_err, 0);
        cyc(); rst_n = 1'b1; #1 chk("mid_fresh_go", ctrl, C_GO);
        cyc(); drive(0, 0, 1, 0, 0, 0, 0, 0, 0); #1 chk("mid_done", ctrl, C_IDLE);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("mid_scnt", stall_cnt, 1);

        for (int i = 0; i < 20; i++) begin
            cyc(); drive(0, 0, 0, 1, 9, 0, 9, 0, 1); #1
            if (i == 5) chk("sat_scnt_mid", stall_cnt, 6);
        end
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("sat_scnt", stall_cnt, 15);
        for (int i = 0; i < 17; i++) begin
            cyc(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1 chk("sat_fcnt", flush_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
